gpu_rect_addrgen: RTL



---
 rtl/gpu_definitions_pkg.sv | 18 +
 rtl/gpu_row_base.sv | 34 +++
 rtl/gpu_rect_addrgen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gpu_definitions_pkg.sv
// Framebuffer geometry defaults and the address-generator state encoding.
// Shared by gpu_rect_addrgen and gpu_row_base; optional clip feature: GPU_ADDRGEN_CLIP_EN.
package gpu_definitions;

   localparam int FB_WIDTH    = 320;
   localparam int FB_HEIGHT   = 240;
   localparam int WIDTH_BITS  = $clog2(FB_WIDTH);
   localparam int HEIGHT_BITS = $clog2(FB_HEIGHT);
   localparam int SUM_BITS    = $clog2(FB_WIDTH * FB_HEIGHT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } addrgen_state_t;

endpackage

// File: rtl/gpu_row_base.sv
// Row base register (ymin*FB_WIDTH, then +FB_WIDTH per row) and the y counter.
// Latency: load/advance take effect on the next clock; no backpressure of its own.
// Backpressure: advance is only pulsed by the parent on an accepted end-of-row beat.
module gpu_row_base #(
   parameter int FB_WIDTH    = 320,
   parameter int HEIGHT_BITS = 8,
   parameter int SUM_BITS    = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   advance,
   input  logic [HEIGHT_BITS-1:0] ymin,
   output logic [SUM_BITS-1:0]    base,
   output logic [HEIGHT_BITS-1:0] y
);

   localparam logic [SUM_BITS-1:0] ROW_STEP = SUM_BITS'(FB_WIDTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base <= '0;
         y    <= '0;
      end else if (load) begin
         // constant multiply, evaluated once per rectangle
         base <= SUM_BITS'(ymin) * ROW_STEP;
         y    <= ymin;
      end else if (advance) begin
         base <= base + ROW_STEP;
         y    <= y + 1'b1;
      end
   end

endmodule

// File: rtl/gpu_rect_addrgen.sv
// Row-major rectangle walker emitting addr = y*FB_WIDTH + x, one beat per accepted handshake.
// Latency: start at N -> first out_valid at N+2; done pulses one cycle after the last handshake.
// Backpressure: out_valid/addr/x/y hold while out_ready is low; GPU_ADDRGEN_CLIP_EN enables clipping.
module gpu_rect_addrgen #(
   parameter int FB_WIDTH    = gpu_definitions::FB_WIDTH,
   parameter int FB_HEIGHT   = gpu_definitions::FB_HEIGHT,
   parameter int WIDTH_BITS  = $clog2(FB_WIDTH),
   parameter int HEIGHT_BITS = $clog2(FB_HEIGHT),
   parameter int SUM_BITS    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WIDTH_BITS-1:0]  x0,
   input  logic [WIDTH_BITS-1:0]  x1,
   input  logic [HEIGHT_BITS-1:0] y0,
   input  logic [HEIGHT_BITS-1:0] y1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SUM_BITS-1:0]    addr,
   output logic [WIDTH_BITS-1:0]  x,
   output logic [HEIGHT_BITS-1:0] y,
   output logic                   busy,
   output logic                   done
);

   import gpu_definitions::*;

   addrgen_state_t state_q, state_d;

   logic [WIDTH_BITS-1:0]  xmin_q, xmax_q, x_q;
   logic [HEIGHT_BITS-1:0] ymin_q, ymax_q, y_cur;
   logic [SUM_BITS-1:0]    base;
   logic                   latch, load_row, adv_row, x_load, x_inc;
   logic                   clip_empty;

`ifdef GPU_ADDRGEN_CLIP_EN
   assign clip_empty = (int'(xmin_q) >= FB_WIDTH) || (int'(ymin_q) >= FB_HEIGHT);
`else
   assign clip_empty = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      latch    = 1'b0;
      load_row = 1'b0;
      adv_row  = 1'b0;
      x_load   = 1'b0;
      x_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               latch   = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            load_row = 1'b1;
            x_load   = 1'b1;
            state_d  = clip_empty ? DONE : RUN;
         end
         RUN: begin
            if (out_ready) begin
               if (x_q < xmax_q) begin
                  x_inc = 1'b1;
               end else if (y_cur < ymax_q) begin
                  // row change folds into the same handshake: no bubble
                  x_load  = 1'b1;
                  adv_row = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         x_q    <= '0;
      end else begin
         if (latch) begin
            xmin_q <= (x0 < x1) ? x0 : x1;
            xmax_q <= (x0 < x1) ? x1 : x0;
            ymin_q <= (y0 < y1) ? y0 : y1;
            ymax_q <= (y0 < y1) ? y1 : y0;
         end
`ifdef GPU_ADDRGEN_CLIP_EN
         if (state_q == SETUP) begin
            if (int'(xmax_q) > FB_WIDTH - 1)  xmax_q <= WIDTH_BITS'(FB_WIDTH - 1);
            if (int'(ymax_q) > FB_HEIGHT - 1) ymax_q <= HEIGHT_BITS'(FB_HEIGHT - 1);
         end
`endif
         if (x_load)     x_q <= xmin_q;
         else if (x_inc) x_q <= x_q + 1'b1;
      end
   end

   gpu_row_base #(
      .FB_WIDTH    (FB_WIDTH),
      .HEIGHT_BITS (HEIGHT_BITS),
      .SUM_BITS    (SUM_BITS)
   ) u_row_base (
      .clk     (clk),
      .rst     (rst),
      .load    (load_row),
      .advance (adv_row),
      .ymin    (ymin_q),
      .base    (base),
      .y       (y_cur)
   );

   assign addr      = base + SUM_BITS'(x_q);
   assign x         = x_q;
   assign y         = y_cur;
   assign out_valid = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule
